// File: rtl/clock_enable_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : clock_enable_scheduler
// Function : Shared prescaler plus per-channel divided single-cycle enables.
//            Define CES_ONESHOT_EN to enable per-channel one-shot mode.
// Revision : 1.0 - initial release
// ============================================================================
module clock_enable_scheduler #(
  parameter int CLK_FREQ  = 12_000_000,
  parameter int BASE_FREQ = 1_000_000,
  parameter int CHANNELS  = 4,
  parameter int DIV_BITS  = 8
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [DIV_BITS-1:0]                                 cfg_div,
  input  logic                                                cfg_run,
  input  logic                                                cfg_oneshot,
  input  logic                                                sync,
  output logic                                                base_tick,
  output logic [CHANNELS-1:0]                                 en,
  output logic [CHANNELS-1:0]                                 running
);

  localparam int c_PRESCALE = CLK_FREQ / BASE_FREQ;
  localparam int c_PRE_BITS = (c_PRESCALE > 1) ? $clog2(c_PRESCALE) : 1;
  localparam int c_CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [c_PRE_BITS-1:0] c_PRE_RELOAD = c_PRE_BITS'(c_PRESCALE - 1);

  logic [c_PRE_BITS-1:0] r_pre;
  logic                  r_base_tick;
  logic                  w_tick;

  assign w_tick    = (r_pre == '0);
  assign base_tick = r_base_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre       <= c_PRE_RELOAD;
      r_base_tick <= 1'b0;
    end else if (sync) begin
      r_pre       <= c_PRE_RELOAD;
      r_base_tick <= 1'b0;
    end else begin
      r_pre       <= w_tick ? c_PRE_RELOAD : r_pre - c_PRE_BITS'(1);
      r_base_tick <= w_tick;
    end
  end

`ifndef CES_ONESHOT_EN
  logic w_unused_oneshot;
  assign w_unused_oneshot = cfg_oneshot;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_BITS-1:0] r_div;
    logic [DIV_BITS-1:0] r_cnt;
    logic                r_run;
    logic                r_en;
    logic                w_sel;
    logic                w_os;

    // Out-of-range indices match no channel, so such writes are dropped.
    assign w_sel      = cfg_we && (cfg_ch == c_CH_BITS'(i));
    assign en[i]      = r_en;
    assign running[i] = r_run;

`ifdef CES_ONESHOT_EN
    logic r_os;
    assign w_os = r_os;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_os <= 1'b0;
      end else if (w_sel) begin
        r_os <= cfg_oneshot;
      end
    end
`else
    assign w_os = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_div <= '0;
        r_cnt <= '0;
        r_run <= 1'b0;
        r_en  <= 1'b0;
      end else if (w_sel) begin
        r_div <= cfg_div;
        r_cnt <= cfg_div;
        r_run <= cfg_run;
        r_en  <= 1'b0;
      end else if (sync) begin
        r_cnt <= r_div;
        r_en  <= 1'b0;
      end else if (w_tick && r_run) begin
        if (r_cnt == '0) begin
          r_en  <= 1'b1;
          r_cnt <= r_div;
          if (w_os) begin
            r_run <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt - DIV_BITS'(1);
          r_en  <= 1'b0;
        end
      end else begin
        r_en <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
